// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, Q-format defaults and fixed-point helpers for the IIR blocks
package iir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_A1,
        ST_MUL_B1,
        ST_MUL_INV,
        ST_OUT
    } state_t;

    localparam int Q_LEN  = 17;
    localparam int Q_FRAC = 16;

    // Move a value between fractional widths; right shifts truncate toward -inf.
    function automatic logic signed [63:0] fxp_align(
        input logic signed [63:0] v,
        input int                 frac_from,
        input int                 frac_to
    );
        if (frac_to >= frac_from)
            return v <<< (frac_to - frac_from);
        else
            return v >>> (frac_from - frac_to);
    endfunction

    // Clamp to the signed range of a len-bit word.
    function automatic logic signed [63:0] fxp_sat(
        input logic signed [63:0] v,
        input int                 len
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (len - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (len - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fxp_mult_trunc.sv
// rtl/fxp_mult_trunc.sv - signed multiply, truncate to target fraction, saturate to target width
module fxp_mult_trunc
    import iir_pkg::*;
#(
    parameter int A_LEN    = Q_LEN,
    parameter int A_FRAC   = Q_FRAC,
    parameter int B_LEN    = Q_LEN,
    parameter int B_FRAC   = Q_FRAC,
    parameter int OUT_LEN  = Q_LEN,
    parameter int OUT_FRAC = Q_FRAC
) (
    input  logic signed [A_LEN-1:0]   a,
    input  logic signed [B_LEN-1:0]   b,
    output logic signed [OUT_LEN-1:0] p
);

    // Full-precision product; nothing is lost before the alignment shift.
    logic signed [A_LEN+B_LEN-1:0] full;

    assign full = a * b;
    assign p    = OUT_LEN'(fxp_sat(fxp_align(64'(full), A_FRAC + B_FRAC, OUT_FRAC), OUT_LEN));

endmodule

// File: rtl/iir_inverse_filter.sv
// rtl/iir_inverse_filter.sv - first-order inverse IIR filter on one time-shared multiplier
module iir_inverse_filter
    import iir_pkg::*;
#(
    parameter int WORD_LEN_IN     = Q_LEN,
    parameter int WORD_FRAC_IN    = Q_FRAC,
    parameter int WORD_LEN_OUT    = Q_LEN,
    parameter int WORD_FRAC_OUT   = Q_FRAC,
    parameter int WORD_LEN_COEF   = Q_LEN,
    parameter int WORD_FRAC_COEF  = Q_FRAC,
    parameter int WORD_LEN_INTER  = Q_LEN,
    parameter int WORD_FRAC_INTER = Q_FRAC
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic signed [WORD_LEN_IN-1:0]    y,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [WORD_LEN_COEF-1:0]  a1,
    input  logic signed [WORD_LEN_COEF-1:0]  b1,
    input  logic signed [WORD_LEN_COEF-1:0]  b0_inv,
    output logic signed [WORD_LEN_OUT-1:0]   x_hat,
    output logic                             out_valid
);

    localparam int L = WORD_LEN_INTER;

    state_t state;
    state_t next_state;

    logic signed [WORD_LEN_IN-1:0]   y_lat;
    logic signed [WORD_LEN_IN-1:0]   y_prev;
    logic signed [WORD_LEN_COEF-1:0] a1_lat;
    logic signed [WORD_LEN_COEF-1:0] b1_lat;
    logic signed [WORD_LEN_COEF-1:0] b0_inv_lat;
    logic signed [L-1:0]             acc;
    logic signed [L-1:0]             res;
    logic signed [L-1:0]             x_prev;
    logic signed [WORD_LEN_OUT-1:0]  x_hat_q;

    logic signed [WORD_LEN_COEF-1:0] mult_a;
    logic signed [L-1:0]             mult_b;
    logic signed [L:0]               mult_p;

    logic signed [L-1:0]             y_inter;
    logic signed [L-1:0]             y_prev_inter;
    logic signed [L-1:0]             acc_minus;
    logic signed [L-1:0]             res_next;
    logic signed [WORD_LEN_OUT-1:0]  res_out;
    logic                            accept;

    assign accept = in_valid && in_ready;

    // Format conversions and the saturating subtract, all in a wide intermediate.
    assign y_inter      = L'(fxp_sat(fxp_align(64'(y), WORD_FRAC_IN, WORD_FRAC_INTER), L));
    assign y_prev_inter = L'(fxp_sat(fxp_align(64'(y_prev), WORD_FRAC_IN, WORD_FRAC_INTER), L));
    assign acc_minus    = L'(fxp_sat(64'(acc) - 64'(mult_p), L));
    assign res_next     = L'(fxp_sat(64'(mult_p), L));
    assign res_out      = WORD_LEN_OUT'(fxp_sat(fxp_align(64'(res), WORD_FRAC_INTER, WORD_FRAC_OUT),
                                                WORD_LEN_OUT));

    // Product kept one bit wider than INTER so the subtract sees the unclamped magnitude.
    fxp_mult_trunc #(
        .A_LEN    (WORD_LEN_COEF),
        .A_FRAC   (WORD_FRAC_COEF),
        .B_LEN    (L),
        .B_FRAC   (WORD_FRAC_INTER),
        .OUT_LEN  (L + 1),
        .OUT_FRAC (WORD_FRAC_INTER)
    ) u_mult (
        .a (mult_a),
        .b (mult_b),
        .p (mult_p)
    );

    // Steer the single multiplier according to the current step.
    always_comb begin
        mult_a = b0_inv_lat;
        mult_b = acc;
        case (state)
            ST_MUL_A1: begin
                mult_a = a1_lat;
                mult_b = y_prev_inter;
            end
            ST_MUL_B1: begin
                mult_a = b1_lat;
                mult_b = x_prev;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; clear aborts any sample in flight.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (accept) next_state = ST_MUL_A1;
                ST_MUL_A1:  next_state = ST_MUL_B1;
                ST_MUL_B1:  next_state = ST_MUL_INV;
                ST_MUL_INV: next_state = ST_OUT;
                ST_OUT:     next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs; a clear cycle neither accepts nor emits a sample.
    always_comb begin
        in_ready  = (state == ST_IDLE) && !clear;
        out_valid = (state == ST_OUT) && !clear;
        x_hat     = out_valid ? res_out : x_hat_q;
    end

    // Datapath: latch at acceptance, accumulate per step, commit history on output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_lat      <= '0;
            y_prev     <= '0;
            a1_lat     <= '0;
            b1_lat     <= '0;
            b0_inv_lat <= '0;
            acc        <= '0;
            res        <= '0;
            x_prev     <= '0;
            x_hat_q    <= '0;
        end else if (clear) begin
            y_prev <= '0;
            x_prev <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        y_lat      <= y;
                        a1_lat     <= a1;
                        b1_lat     <= b1;
                        b0_inv_lat <= b0_inv;
                        acc        <= y_inter;
                    end
                end
                ST_MUL_A1:  acc <= acc_minus;
                ST_MUL_B1:  acc <= acc_minus;
                ST_MUL_INV: res <= res_next;
                ST_OUT: begin
                    x_hat_q <= res_out;
                    y_prev  <= y_lat;
                    x_prev  <= res;
                end
                default: ;
            endcase
        end
    end

endmodule
